// File: rtl/lines_sequencer_if.sv
// Control bundle between the round sequencer and the horizontal-line datapath.
// The sequencer side (master) samples the frame/button/collision inputs and drives the per-line controls.
interface lines_sequencer_if #(
   parameter int N_LINES = 4
);
   logic               frame;
   logic               go;
   logic               pause;
   logic               collision;
   logic               load_counter;
   logic [N_LINES-1:0] start_machine;
   logic [N_LINES-1:0] stop;
   logic               flash;
   logic [15:0]        score;
   logic               game_over;
   logic [2:0]         state;

   modport master (
      input  frame, go, pause, collision,
      output load_counter, start_machine, stop, flash, score, game_over, state
   );

   modport slave (
      output frame, go, pause, collision,
      input  load_counter, start_machine, stop, flash, score, game_over, state
   );
endinterface

// File: rtl/lines_sequencer.sv
// Game-round controller: loads the lines, launches them one per LAUNCH_GAP frames,
// detects a collision, flashes the frozen field and reports game over.
module lines_sequencer #(
   parameter int N_LINES       = 4,
   parameter int LAUNCH_GAP    = 60,
   parameter int FLASH_PERIOD  = 15,
   parameter int FLASH_TOGGLES = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   lines_sequencer_if.master    bus
);

   typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, PLAY, PAUSE, HIT, OVER} state_t;

   localparam int IDX_W = $clog2(N_LINES + 1);
   localparam int GAP_W = $clog2(LAUNCH_GAP + 1);
   localparam int FP_W  = $clog2(FLASH_PERIOD + 1);
   localparam int TG_W  = $clog2(FLASH_TOGGLES + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LAUNCH_GAP - 1);
   localparam logic [FP_W-1:0]  FP_LAST  = FP_W'(FLASH_PERIOD - 1);
   localparam logic [TG_W-1:0]  TG_LAST  = TG_W'(FLASH_TOGGLES - 1);
   localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(N_LINES);

   state_t             state_q, saved_q;
   logic [IDX_W-1:0]   idx_q;
   logic [GAP_W-1:0]   gap_q;
   logic [FP_W-1:0]    flash_cnt_q;
   logic [TG_W-1:0]    toggle_q;
   logic               pulse_q;
   logic               armed_q;
   logic               load_q, flash_q, over_q;
   logic [N_LINES-1:0] start_q, stop_q;
   logic [15:0]        score_q;

   logic [N_LINES-1:0] launched_mask, next_oh, last_oh;
   logic               hit_now;

   // All pulses are one clk wide and level-free: an input counts on every cycle it is high.
   always_comb begin
      launched_mask = '0;
      next_oh       = '0;
      last_oh       = '0;
      for (int i = 0; i < N_LINES; i++) begin
         launched_mask[i] = (IDX_W'(i) < idx_q);
         next_oh[i]       = (IDX_W'(i) == idx_q);
         last_oh[i]       = (IDX_W'(i + 1) == idx_q);
      end
   end

   assign hit_now = bus.frame && bus.collision && (state_q == LAUNCH || state_q == PLAY);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         saved_q     <= IDLE;
         idx_q       <= '0;
         gap_q       <= '0;
         flash_cnt_q <= '0;
         toggle_q    <= '0;
         pulse_q     <= 1'b0;
         armed_q     <= 1'b0;
         load_q      <= 1'b1;
         flash_q     <= 1'b1;
         over_q      <= 1'b0;
         start_q     <= '0;
         stop_q      <= '0;
         score_q     <= '0;
      end else begin
         // go is only honoured from the second clk after reset release
         armed_q <= 1'b1;
         case (state_q)
            IDLE, OVER: begin
               if (bus.go && armed_q) begin
                  state_q <= LOAD;
                  load_q  <= 1'b1;
                  score_q <= '0;
                  idx_q   <= '0;
                  over_q  <= 1'b0;
                  flash_q <= 1'b1;
                  stop_q  <= '0;
                  start_q <= '0;
                  pulse_q <= 1'b0;
               end
            end
            LOAD: begin
               if (bus.frame) begin
                  state_q <= LAUNCH;
                  load_q  <= 1'b0;
                  start_q <= next_oh;
                  stop_q  <= stop_q | next_oh;
                  idx_q   <= idx_q + 1'b1;
                  gap_q   <= '0;
                  pulse_q <= 1'b1;
               end
            end
            LAUNCH, PLAY: begin
               if (hit_now) begin
                  state_q     <= HIT;
                  stop_q      <= '0;
                  start_q     <= '0;
                  pulse_q     <= 1'b0;
                  flash_q     <= 1'b1;
                  flash_cnt_q <= '0;
                  toggle_q    <= '0;
               end else if (bus.pause) begin
                  saved_q     <= state_q;
                  state_q     <= PAUSE;
                  stop_q      <= '0;
                  start_q     <= '0;
                  flash_cnt_q <= '0;
               end else if (bus.frame) begin
                  if (state_q == PLAY) begin
                     if (score_q != 16'hFFFF) score_q <= score_q + 16'd1;
                  end else begin
                     if (pulse_q) begin
                        start_q <= '0;
                        pulse_q <= 1'b0;
                     end
                     // the frame that ends the last line's pulse hands over to PLAY
                     if (idx_q == IDX_END) begin
                        state_q <= PLAY;
                     end else if (gap_q == GAP_LAST) begin
                        start_q <= next_oh;
                        stop_q  <= stop_q | next_oh;
                        idx_q   <= idx_q + 1'b1;
                        gap_q   <= '0;
                        pulse_q <= 1'b1;
                     end else begin
                        gap_q <= gap_q + 1'b1;
                     end
                  end
               end
            end
            PAUSE: begin
               if (bus.pause) begin
                  state_q <= saved_q;
                  flash_q <= 1'b1;
                  stop_q  <= launched_mask;
                  start_q <= pulse_q ? last_oh : '0;
               end else if (bus.frame) begin
                  if (flash_cnt_q == FP_LAST) begin
                     flash_cnt_q <= '0;
                     flash_q     <= ~flash_q;
                  end else begin
                     flash_cnt_q <= flash_cnt_q + 1'b1;
                  end
               end
            end
            HIT: begin
               if (bus.frame) begin
                  if (flash_cnt_q == FP_LAST) begin
                     flash_cnt_q <= '0;
                     toggle_q    <= toggle_q + 1'b1;
                     flash_q     <= ~flash_q;
                     if (toggle_q == TG_LAST) begin
                        state_q <= OVER;
                        over_q  <= 1'b1;
                        flash_q <= 1'b1;
                     end
                  end else begin
                     flash_cnt_q <= flash_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.load_counter  = load_q;
   assign bus.start_machine = start_q;
   assign bus.stop          = stop_q;
   assign bus.flash         = flash_q;
   assign bus.score         = score_q;
   assign bus.game_over     = over_q;
   assign bus.state         = state_q;

endmodule

// File: tb/tb_lines_sequencer.sv
// Bench for lines_sequencer: launch schedule, collision/flash, pause, score saturation, async reset.
module tb_lines_sequencer;

   localparam int N   = 4;
   localparam int GAP = 3;
   localparam int FP  = 2;
   localparam int FT  = 4;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_LAUNCH = 3'd2;
   localparam logic [2:0] S_PLAY   = 3'd3;
   localparam logic [2:0] S_PAUSE  = 3'd4;
   localparam logic [2:0] S_HIT    = 3'd5;
   localparam logic [2:0] S_OVER   = 3'd6;

   // {load_counter, flash, game_over, state, stop, start_machine} at reset
   localparam logic [13:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 3'd0, 4'h0, 4'h0};

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   lines_sequencer_if #(.N_LINES(N)) bus ();

   lines_sequencer #(
      .N_LINES(N), .LAUNCH_GAP(GAP), .FLASH_PERIOD(FP), .FLASH_TOGGLES(FT)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   int total = 0;
   int bad = 0;
   logic [15:0] exp_q[$];
   logic [15:0] got, exp_v;

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_frame();
      bus.frame = 1'b1;
      @(negedge clk);
      bus.frame = 1'b0;
   endtask

   task automatic next_frame();
      idle(9);
      pulse_frame();
   endtask

   task automatic pulse_go();
      bus.go = 1'b1;
      @(negedge clk);
      bus.go = 1'b0;
   endtask

   task automatic pulse_pause();
      bus.pause = 1'b1;
      @(negedge clk);
      bus.pause = 1'b0;
   endtask

   task automatic test_reset();
      got = {2'b00, bus.load_counter, bus.flash, bus.game_over, bus.state, bus.stop, bus.start_machine};
      total++;
      if (got[13:0] !== RESET_VEC) begin
         bad++; $display("FAIL reset_outputs got=%h exp=%h", got[13:0], RESET_VEC);
      end
      total++;
      if (bus.score !== 16'h0000) begin
         bad++; $display("FAIL reset_score got=%h exp=0000", bus.score);
      end
   endtask

   task automatic test_launch_play();
      for (int f = 0; f <= 10; f++) begin
         logic [3:0] s, m;
         s = '0; m = '0;
         for (int k = 0; k < N; k++) begin
            if (f == k * GAP) s[k] = 1'b1;
            if (f >= k * GAP) m[k] = 1'b1;
         end
         exp_q.push_back({8'h00, m, s});
      end
      pulse_go();
      total++;
      if (bus.state !== S_LOAD || bus.load_counter !== 1'b1) begin
         bad++; $display("FAIL go_to_load got=%0d/%b exp=%0d/1", bus.state, bus.load_counter, S_LOAD);
      end
      idle(5);
      for (int f = 0; f <= 10; f++) begin
         if (f > 0) idle(9);
         pulse_frame();
         got = {8'h00, bus.stop, bus.start_machine};
         exp_v = exp_q.pop_front();
         total++;
         if (got !== exp_v) begin
            bad++; $display("FAIL launch_f%0d got=%h exp=%h", f, got, exp_v);
         end
         if (f == 0) begin
            total++;
            if (bus.load_counter !== 1'b0) begin
               bad++; $display("FAIL load_drop got=%b exp=0", bus.load_counter);
            end
         end
      end
      total++;
      if (bus.state !== S_PLAY || bus.score !== 16'h0000) begin
         bad++; $display("FAIL play_entry got=%0d/%h exp=%0d/0000", bus.state, bus.score, S_PLAY);
      end
      for (int i = 1; i <= 3; i++) exp_q.push_back(16'(i));
      for (int i = 1; i <= 3; i++) begin
         next_frame();
         exp_v = exp_q.pop_front();
         total++;
         if (bus.score !== exp_v) begin
            bad++; $display("FAIL score_%0d got=%h exp=%h", i, bus.score, exp_v);
         end
      end
   endtask

   task automatic test_collision_play();
      bus.collision = 1'b1;
      next_frame();
      bus.collision = 1'b0;
      total++;
      if (bus.state !== S_HIT || bus.stop !== 4'h0 || bus.flash !== 1'b1) begin
         bad++; $display("FAIL play_hit got=%0d/%h/%b exp=%0d/0/1", bus.state, bus.stop, bus.flash, S_HIT);
      end
      for (int f = 1; f <= 2 * FT; f++) begin
         logic fl;
         fl = ((f / FP) % 2 == 0);
         exp_q.push_back({14'h0, (f >= 2 * FT), fl});
      end
      for (int f = 1; f <= 2 * FT; f++) begin
         next_frame();
         got = {14'h0, bus.game_over, bus.flash};
         exp_v = exp_q.pop_front();
         total++;
         if (got !== exp_v) begin
            bad++; $display("FAIL hit_flash_f%0d got=%h exp=%h", f, got, exp_v);
         end
      end
      total++;
      if (bus.state !== S_OVER || bus.score !== 16'd3 || bus.stop !== 4'h0) begin
         bad++; $display("FAIL over_state got=%0d/%h/%h exp=%0d/0003/0", bus.state, bus.score, bus.stop, S_OVER);
      end
   endtask

   task automatic test_collision_launch();
      pulse_go();
      total++;
      if (bus.state !== S_LOAD || bus.score !== 16'h0 || bus.game_over !== 1'b0 || bus.load_counter !== 1'b1) begin
         bad++; $display("FAIL replay got=%0d/%h/%b/%b exp=%0d/0000/0/1",
                         bus.state, bus.score, bus.game_over, bus.load_counter, S_LOAD);
      end
      idle(5);
      exp_q.push_back(16'h0011);
      exp_q.push_back(16'h0010);
      exp_q.push_back(16'h0010);
      exp_q.push_back(16'h0032);
      for (int f = 0; f < 4; f++) begin
         if (f > 0) idle(9);
         pulse_frame();
         got = {8'h00, bus.stop, bus.start_machine};
         exp_v = exp_q.pop_front();
         total++;
         if (got !== exp_v) begin
            bad++; $display("FAIL cl_launch_f%0d got=%h exp=%h", f, got, exp_v);
         end
      end
      bus.collision = 1'b1;
      next_frame();
      bus.collision = 1'b0;
      total++;
      if (bus.state !== S_HIT || bus.stop !== 4'h0 || bus.start_machine !== 4'h0) begin
         bad++; $display("FAIL launch_hit got=%0d/%h/%h exp=%0d/0/0", bus.state, bus.stop, bus.start_machine, S_HIT);
      end
      for (int f = 1; f <= 2 * FT + 2; f++) begin
         next_frame();
         total++;
         if (bus.start_machine !== 4'h0 || bus.stop !== 4'h0) begin
            bad++; $display("FAIL no_launch_f%0d got=%h/%h exp=0/0", f, bus.start_machine, bus.stop);
         end
      end
      total++;
      if (bus.game_over !== 1'b1) begin
         bad++; $display("FAIL launch_over got=%b exp=1", bus.game_over);
      end
   endtask

   task automatic test_pause();
      pulse_go();
      idle(5);
      pulse_frame();
      total++;
      if (bus.start_machine !== 4'h1) begin
         bad++; $display("FAIL pause_pre got=%h exp=1", bus.start_machine);
      end
      idle(4);
      pulse_pause();
      total++;
      if (bus.state !== S_PAUSE || bus.stop !== 4'h0 || bus.start_machine !== 4'h0) begin
         bad++; $display("FAIL pause_enter got=%0d/%h/%h exp=%0d/0/0", bus.state, bus.stop, bus.start_machine, S_PAUSE);
      end
      bus.collision = 1'b1;
      for (int p = 1; p <= 4; p++) exp_q.push_back({15'h0, ((p / FP) % 2 == 0)});
      for (int p = 1; p <= 4; p++) begin
         next_frame();
         exp_v = exp_q.pop_front();
         total++;
         if (bus.flash !== exp_v[0] || bus.state !== S_PAUSE) begin
            bad++; $display("FAIL pause_f%0d got=%b/%0d exp=%b/%0d", p, bus.flash, bus.state, exp_v[0], S_PAUSE);
         end
      end
      bus.collision = 1'b0;
      idle(4);
      pulse_pause();
      total++;
      if (bus.state !== S_LAUNCH || bus.start_machine !== 4'h1 || bus.stop !== 4'h1 || bus.flash !== 1'b1) begin
         bad++; $display("FAIL resume got=%0d/%h/%h/%b exp=%0d/1/1/1",
                         bus.state, bus.start_machine, bus.stop, bus.flash, S_LAUNCH);
      end
      exp_q.push_back(16'h0010);
      exp_q.push_back(16'h0010);
      exp_q.push_back(16'h0032);
      for (int r = 1; r <= 3; r++) begin
         next_frame();
         got = {8'h00, bus.stop, bus.start_machine};
         exp_v = exp_q.pop_front();
         total++;
         if (got !== exp_v) begin
            bad++; $display("FAIL resume_f%0d got=%h exp=%h", r, got, exp_v);
         end
      end
   endtask

   task automatic test_saturation();
      idle(3);
      bus.frame = 1'b1;
      repeat (66000) @(negedge clk);
      bus.frame = 1'b0;
      total++;
      if (bus.state !== S_PLAY || bus.score !== 16'hFFFF) begin
         bad++; $display("FAIL saturate got=%0d/%h exp=%0d/ffff", bus.state, bus.score, S_PLAY);
      end
      idle(3);
      bus.collision = 1'b1;
      pulse_frame();
      bus.collision = 1'b0;
      for (int f = 1; f <= 2 * FT; f++) next_frame();
      total++;
      if (bus.state !== S_OVER || bus.game_over !== 1'b1 || bus.score !== 16'hFFFF) begin
         bad++; $display("FAIL sat_over got=%0d/%b/%h exp=%0d/1/ffff", bus.state, bus.game_over, bus.score, S_OVER);
      end
      pulse_go();
      total++;
      if (bus.state !== S_LOAD || bus.score !== 16'h0 || bus.game_over !== 1'b0) begin
         bad++; $display("FAIL sat_replay got=%0d/%h/%b exp=%0d/0000/0", bus.state, bus.score, bus.game_over, S_LOAD);
      end
   endtask

   task automatic test_async_reset();
      idle(3);
      pulse_frame();
      bus.collision = 1'b1;
      next_frame();
      bus.collision = 1'b0;
      next_frame();
      next_frame();
      total++;
      if (bus.state !== S_HIT || bus.flash !== 1'b0) begin
         bad++; $display("FAIL mid_hit got=%0d/%b exp=%0d/0", bus.state, bus.flash, S_HIT);
      end
      idle(4);
      #2 reset_n = 1'b0;
      #1;
      got = {2'b00, bus.load_counter, bus.flash, bus.game_over, bus.state, bus.stop, bus.start_machine};
      total++;
      if (got[13:0] !== RESET_VEC) begin
         bad++; $display("FAIL async_reset got=%h exp=%h", got[13:0], RESET_VEC);
      end
      @(negedge clk);
      reset_n = 1'b1;
      bus.go = 1'b1;
      @(negedge clk);
      bus.go = 1'b0;
      total++;
      if (bus.state !== S_IDLE || bus.load_counter !== 1'b1) begin
         bad++; $display("FAIL go_at_release got=%0d/%b exp=%0d/1", bus.state, bus.load_counter, S_IDLE);
      end
      pulse_go();
      total++;
      if (bus.state !== S_LOAD) begin
         bad++; $display("FAIL go_after_release got=%0d exp=%0d", bus.state, S_LOAD);
      end
   endtask

   initial begin
      bus.frame     = 1'b0;
      bus.go        = 1'b0;
      bus.pause     = 1'b0;
      bus.collision = 1'b0;
      reset_n       = 1'b0;
      idle(3);
      reset_n = 1'b1;
      idle(2);
      test_reset();
      test_launch_play();
      test_collision_play();
      test_collision_launch();
      test_pause();
      test_saturation();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
